uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single UART TX FIFO write port (write_uart/write_data) among
//  NUM_REQ byte-stream requesters. Message-locked: a winner keeps the port until its last byte or MAX_BURST bytes.
//  Sits between uart_top's write side and several producers (echo path, status reporter, command replies).
// PARAMETERS
//  NUM_REQ         4    number of requesters (2..8)
//  MAX_BURST       16   max bytes per grant before forced rotation (1..255)
//  TIMEOUT_CYCLES  1000 idle-grant cycles before forced release (ARB_TIMEOUT_EN only; >=2)
// PORTS
//  clk_100MHz  in   1          system clock
//  reset       in   1          asynchronous, active-low reset
//  req_valid   in   NUM_REQ    requester i has a byte on req_data[8*i+:8]
//  req_data    in   8*NUM_REQ  packed request bytes
//  req_last    in   NUM_REQ    byte presented by requester i is the last of its message
//  req_ready   out  NUM_REQ    byte of requester i accepted this cycle when req_valid[i]&req_ready[i]
//  tx_full     in   1          TX FIFO full (from uart_top)
//  write_uart  out  1          TX FIFO write strobe, one cycle per byte
//  write_data  out  8          TX FIFO write byte
//  grant       out  NUM_REQ    registered one-hot grant, all-zero when idle
//  busy        out  1          a grant is held
//  timeout     out  1          one-cycle pulse on forced release by timeout (tied 0 without macro)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, grant=0, busy=0, timeout=0, beat_cnt=0, idle_cnt=0,
//    rr_ptr=NUM_REQ-1 (requester 0 wins first). write_uart=0 and req_ready=0 follow from grant=0.
//  - FSM IDLE: if any req_valid, winner = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ;
//    grant<=onehot(winner), busy<=1, -> LOCKED. One cycle arbitration latency; no byte accepted in IDLE.
//  - FSM LOCKED (granted g): req_ready[g] = ~tx_full (combinational); others 0.
//    accept = req_valid[g] & ~tx_full; write_uart = accept; write_data = req_data[8*g+:8] (0 when not busy).
//    Zero latency from accept to write_uart; never strobe when tx_full=1.
//  - On accept: beat_cnt++. Release when accept & (req_last[g] | beat_cnt==MAX_BURST-1):
//    grant<=0, busy<=0, rr_ptr<=g, beat_cnt<=0, -> IDLE. Next winner arbitrated in the following cycle.
//  - req_valid dropping mid-message does not release (message lock); only last, MAX_BURST or timeout do.
//  - tx_full stall: holds grant, no strobe, beat_cnt unchanged, does not count as idle.
//  - Requester i must hold req_data/req_last stable while req_valid[i]&~req_ready[i].
//  - Simultaneous requests: strictly round-robin; a requester cannot win twice while another waits.
//  - NUM_REQ=1: degenerates to pass-through with 1-cycle initial latency and re-arbitration after each release.
//  - Reset mid-message: grant dropped immediately; partial message not completed; no strobe after assert.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: in LOCKED, idle_cnt++ each cycle with req_valid[g]=0 & tx_full=0, cleared on accept.
//    idle_cnt==TIMEOUT_CYCLES-1 -> release exactly as normal (rr_ptr<=g) and pulse timeout for one cycle.
//  ARB_TIMEOUT_EN undefined: no idle counter; timeout tied 0; grant held indefinitely until last/MAX_BURST.
// TESTING
//  1 Reset, req_valid=4'b1111, all last=1, tx_full=0 -> grants 0,1,2,3,0 in order; one write_uart per grant,
//    write_data matches req_data of granted requester; 2 cycles per byte (arbitrate + accept).
//  2 Req1 sends 3-byte msg 0x41,0x42,0x43(last) while req2 valid -> 3 consecutive strobes from req1, then req2.
//  3 Req0 streams 20 bytes no last, MAX_BURST=16, req3 valid -> after 16th byte grant moves to req3;
//    req0 regains after req3 message, remaining 4 bytes follow.
//  4 tx_full=1 for 5 cycles mid-message -> write_uart=0, req_ready=0, grant held; bytes resume unchanged, none lost.
//  5 (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) req2 granted then drops valid -> release after 8 idle cycles,
//    timeout pulses once, req3 granted next; without macro grant still held after 100 cycles.
//  6 Assert reset during LOCKED mid-message -> grant=0, busy=0, write_uart=0 same cycle; after release req0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-FIFO write-side bundle for uart_tx_arbiter.
// master = producers + FIFO side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_full;
  logic                 write_uart;
  logic [7:0]           write_data;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, write_uart, write_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, write_uart, write_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter for the UART TX FIFO write port.
// Optional idle-grant timeout release enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic               busy_n;
  logic [IW-1:0]      rr_ptr, rr_ptr_n;
  logic [7:0]         beat_cnt, beat_n;
  logic [IW-1:0]      g, win, cand;
  logic [IW:0]        sum;
  logic               found, accept, rel_msg;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt, idle_n;
  logic          timeout_n;
`endif

  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) g = IW'(i);
  end

  assign accept  = busy & bus.req_valid[g] & ~bus.tx_full;
  assign rel_msg = accept &
    (bus.req_last[g] | (beat_cnt == 8'(MAX_BURST - 1)));

  assign bus.req_ready  = grant & {NUM_REQ{~bus.tx_full}};
  assign bus.write_uart = accept;
  assign bus.write_data = busy ? bus.req_data[{g, 3'b000} +: 8]
                               : 8'h00;

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    busy_n   = busy;
    rr_ptr_n = rr_ptr;
    beat_n   = beat_cnt;
    found    = 1'b0;
    win      = '0;
    sum      = '0;
    cand     = '0;
`ifdef ARB_TIMEOUT_EN
    idle_n    = idle_cnt;
    timeout_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // search starts just after the last winner
        for (int k = 1; k <= NUM_REQ; k++) begin
          sum = {1'b0, rr_ptr} + (IW+1)'(k);
          if (sum >= (IW+1)'(NUM_REQ))
            sum = sum - (IW+1)'(NUM_REQ);
          cand = sum[IW-1:0];
          if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found) begin
          grant_n      = '0;
          grant_n[win] = 1'b1;
          busy_n       = 1'b1;
          beat_n       = '0;
          state_n      = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          beat_n = beat_cnt + 8'd1;
`ifdef ARB_TIMEOUT_EN
          idle_n = '0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (!bus.req_valid[g] && !bus.tx_full) begin
          if (idle_cnt == TW'(TIMEOUT_CYCLES - 1))
            timeout_n = 1'b1;
          else
            idle_n = idle_cnt + TW'(1);
        end
        if (rel_msg || timeout_n) begin
          idle_n = '0;
`else
        if (rel_msg) begin
`endif
          grant_n  = '0;
          busy_n   = 1'b0;
          rr_ptr_n = g;
          beat_n   = '0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      busy     <= busy_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      idle_cnt <= idle_n;
      timeout  <= timeout_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round robin, message lock,
// burst limit, FIFO-full stall, idle timeout and async reset.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .MAX_BURST(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_100MHz(clk),
    .reset(rst_n),
    .bus(bus),
    .grant(grant),
    .busy(busy),
    .timeout(timeout)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0]   q [N][$];
  logic [N-1:0] en, vld;
  logic         txf;
  logic         s_wu, s_busy, s_to;
  logic [7:0]   s_wd;
  logic [N-1:0] s_g, s_rdy;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      vld[i] = en[i] && (q[i].size() != 0);
      bus.req_valid[i]       = vld[i];
      bus.req_data[8*i +: 8] = 8'h00;
      bus.req_last[i]        = 1'b0;
      if (vld[i]) begin
        bus.req_data[8*i +: 8] = q[i][0][7:0];
        bus.req_last[i]        = q[i][0][8];
      end
    end
    bus.tx_full = txf;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    s_wu   = bus.write_uart;
    s_wd   = bus.write_data;
    s_g    = grant;
    s_busy = busy;
    s_rdy  = bus.req_ready;
    s_to   = timeout;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (vld[i] && s_rdy[i]) void'(q[i].pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    txf   = 1'b0;
    en    = '1;
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    txf   = 1'b0;
    en    = '1;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      q[i].push_back({1'b1, 8'(8'hE0 + i)});
    end
    drive();
    @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs grant=%b busy=%b timeout=%b exp 0000/0/0",
               grant, busy, timeout);
    end
    checks++;
    if (bus.write_uart !== 1'b0 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL reset_outs write_uart=%b req_ready=%b exp 0/0000",
               bus.write_uart, bus.req_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (s_wu !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_arb_cycle write_uart=%b busy=%b exp 0/0",
               s_wu, s_busy);
    end
    cycle();
    checks++;
    if (s_g !== 4'b0001 || s_wu !== 1'b1 || s_wd !== 8'hE0) begin
      failures++;
      $display("FAIL reset_first_win grant=%b wu=%b data=%h exp 0001/1/e0",
               s_g, s_wu, s_wd);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    logic [7:0]   ed;
    do_reset();
    for (int i = 0; i < N; i++) begin
      q[i].push_back({1'b1, 8'(8'h10 + i)});
      q[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    for (int n = 0; n < 5; n++) begin
      cycle();
      checks++;
      if (s_wu !== 1'b0 || s_busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_arb[%0d] wu=%b busy=%b exp 0/0", n, s_wu, s_busy);
      end
      cycle();
      eg = 4'b0001 << (n % 4);
      ed = (n < 4) ? 8'(8'h10 + n) : 8'h20;
      checks++;
      if (s_wu !== 1'b1 || s_g !== eg || s_wd !== ed || s_busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_write[%0d] wu=%b grant=%b data=%h exp 1/%b/%h",
                 n, s_wu, s_g, s_wd, eg, ed);
      end
    end
  endtask

  task automatic test_message_lock();
    logic         ew [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] eg [6] = '{4'b0000, 4'b0010, 4'b0010,
                             4'b0010, 4'b0000, 4'b0100};
    logic [7:0]   ed [6] = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h00, 8'h55};
    do_reset();
    q[1].push_back({1'b0, 8'h41});
    q[1].push_back({1'b0, 8'h42});
    q[1].push_back({1'b1, 8'h43});
    q[2].push_back({1'b1, 8'h55});
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if (s_wu !== ew[c] || s_g !== eg[c] || (ew[c] && s_wd !== ed[c])) begin
        failures++;
        $display("FAIL msg_lock[%0d] wu=%b grant=%b data=%h exp %b/%b/%h",
                 c, s_wu, s_g, s_wd, ew[c], eg[c], ed[c]);
      end
    end
  endtask

  task automatic test_max_burst();
    logic [11:0] got [$];
    logic [11:0] exp [$];
    do_reset();
    for (int k = 0; k < 20; k++) q[0].push_back({1'b0, 8'(k)});
    q[3].push_back({1'b0, 8'hA0});
    q[3].push_back({1'b1, 8'hA1});
    for (int k = 0; k < 16; k++) exp.push_back({4'b0001, 8'(k)});
    exp.push_back({4'b1000, 8'hA0});
    exp.push_back({4'b1000, 8'hA1});
    for (int k = 16; k < 20; k++) exp.push_back({4'b0001, 8'(k)});
    for (int c = 0; c < 25; c++) begin
      cycle();
      if (s_wu) got.push_back({s_g, s_wd});
    end
    checks++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("FAIL burst_count got=%0d exp=%0d", got.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp[k]) begin
        failures++;
        $display("FAIL burst_byte[%0d] grant/data=%h exp=%h", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] ed [3] = '{8'h62, 8'h63, 8'h64};
    do_reset();
    q[2].push_back({1'b0, 8'h61});
    q[2].push_back({1'b0, 8'h62});
    q[2].push_back({1'b0, 8'h63});
    q[2].push_back({1'b1, 8'h64});
    cycle();
    cycle();
    checks++;
    if (s_wu !== 1'b1 || s_wd !== 8'h61 || s_g !== 4'b0100) begin
      failures++;
      $display("FAIL full_first wu=%b data=%h grant=%b exp 1/61/0100",
               s_wu, s_wd, s_g);
    end
    txf = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++;
      if (s_wu !== 1'b0 || s_rdy !== '0 || s_g !== 4'b0100 || s_busy !== 1'b1) begin
        failures++;
        $display("FAIL full_stall[%0d] wu=%b ready=%b grant=%b busy=%b exp 0/0000/0100/1",
                 c, s_wu, s_rdy, s_g, s_busy);
      end
    end
    txf = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (s_wu !== 1'b1 || s_wd !== ed[c] || s_rdy !== 4'b0100) begin
        failures++;
        $display("FAIL full_resume[%0d] wu=%b data=%h ready=%b exp 1/%h/0100",
                 c, s_wu, s_wd, s_rdy, ed[c]);
      end
    end
    cycle();
    checks++;
    if (s_busy !== 1'b0 || s_g !== '0) begin
      failures++;
      $display("FAIL full_release busy=%b grant=%b exp 0/0000", s_busy, s_g);
    end
  endtask

  task automatic test_timeout();
    int writes;
    int pulses;
    do_reset();
    q[2].push_back({1'b0, 8'h71});
    q[3].push_back({1'b1, 8'hB0});
    cycle();
    cycle();
    checks++;
    if (s_wu !== 1'b1 || s_wd !== 8'h71 || s_g !== 4'b0100) begin
      failures++;
      $display("FAIL to_first wu=%b data=%h grant=%b exp 1/71/0100",
               s_wu, s_wd, s_g);
    end
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      cycle();
      checks++;
      if (s_g !== 4'b0100 || s_to !== 1'b0) begin
        failures++;
        $display("FAIL to_hold[%0d] grant=%b timeout=%b exp 0100/0", c, s_g, s_to);
      end
    end
    cycle();
    checks++;
    if (s_to !== 1'b1 || s_g !== '0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse timeout=%b grant=%b busy=%b exp 1/0000/0",
               s_to, s_g, s_busy);
    end
    cycle();
    checks++;
    if (s_to !== 1'b0 || s_g !== 4'b1000 || s_wu !== 1'b1 || s_wd !== 8'hB0) begin
      failures++;
      $display("FAIL to_next timeout=%b grant=%b wu=%b data=%h exp 0/1000/1/b0",
               s_to, s_g, s_wu, s_wd);
    end
`else
    writes = 0;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (s_wu) writes++;
      if (s_to) pulses++;
    end
    checks++;
    if (s_g !== 4'b0100 || s_busy !== 1'b1) begin
      failures++;
      $display("FAIL to_held grant=%b busy=%b exp 0100/1", s_g, s_busy);
    end
    checks++;
    if (writes != 0 || pulses != 0) begin
      failures++;
      $display("FAIL to_quiet writes=%0d pulses=%0d exp 0/0", writes, pulses);
    end
`endif
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    q[1].push_back({1'b0, 8'h81});
    q[1].push_back({1'b0, 8'h82});
    q[1].push_back({1'b1, 8'h83});
    cycle();
    cycle();
    checks++;
    if (s_wu !== 1'b1 || s_wd !== 8'h81 || s_g !== 4'b0010) begin
      failures++;
      $display("FAIL mid_first wu=%b data=%h grant=%b exp 1/81/0010",
               s_wu, s_wd, s_g);
    end
    drive();
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || bus.write_uart !== 1'b0) begin
      failures++;
      $display("FAIL mid_async grant=%b busy=%b wu=%b exp 0000/0/0",
               grant, busy, bus.write_uart);
    end
    q[0].push_back({1'b1, 8'h90});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (s_wu !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_arb wu=%b busy=%b exp 0/0", s_wu, s_busy);
    end
    cycle();
    checks++;
    if (s_g !== 4'b0001 || s_wu !== 1'b1 || s_wd !== 8'h90) begin
      failures++;
      $display("FAIL mid_rewin grant=%b wu=%b data=%h exp 0001/1/90",
               s_g, s_wu, s_wd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    txf   = 1'b0;
    en    = '1;
    drive();
    #1;
    test_reset();
    test_round_robin();
    test_message_lock();
    test_max_burst();
    test_tx_full();
    test_timeout();
    test_reset_mid_message();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
